// File: rtl/goruntu_pkg.sv
// Shared defaults, pixel type and controller states for the image pipeline.
package goruntu_pkg;

    localparam int VARS_GENISLIK  = 320;
    localparam int VARS_YUKSEKLIK = 240;
    localparam int VARS_VERI_W    = 8;

    typedef logic [VARS_VERI_W-1:0] piksel_t;

    typedef enum logic [1:0] {
        BOS    = 2'd0,
        DOLDUR = 2'd1,
        AKIS   = 2'd2,
        BOSALT = 2'd3
    } durum_t;

endpackage

// File: rtl/pencere_3x3_satir_tamponu.sv
// One image line of storage: simple dual-port RAM with registered,
// read-before-write output.
module satir_tamponu #(
    parameter int DERINLIK = 320,
    parameter int VERI_W   = 8,
    parameter int AW       = $clog2(DERINLIK)
) (
    input  logic              clk_i,
    input  logic              yaz_en_i,
    input  logic [AW-1:0]     yaz_adr_i,
    input  logic [VERI_W-1:0] yaz_veri_i,
    input  logic [AW-1:0]     oku_adr_i,
    output logic [VERI_W-1:0] oku_veri_o
);

    logic [VERI_W-1:0] bellek [DERINLIK];

    always_ff @(posedge clk_i) begin
        oku_veri_o <= bellek[oku_adr_i];
        if (yaz_en_i) begin
            bellek[yaz_adr_i] <= yaz_veri_i;
        end
    end

endmodule

// File: rtl/pencere_3x3.sv
// Streaming zero-padded 3x3 window generator built on two line buffers.
//
// state  | meaning
// BOS    | idle, waiting for pixel 0 of a frame
// DOLDUR | priming line buffers, pixels 0..GENISLIK, no windows yet
// AKIS   | each accepted pixel k emits window k-(GENISLIK+1)
// BOSALT | input blocked, flushing the last GENISLIK+1 windows
module pencere_3x3
    import goruntu_pkg::*;
#(
    parameter int                GENISLIK  = VARS_GENISLIK,
    parameter int                YUKSEKLIK = VARS_YUKSEKLIK,
    parameter int                VERI_W    = VARS_VERI_W,
    parameter logic [VERI_W-1:0] PAD_DEGER = '0
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         en_i,
    input  logic                         veri_gecerli_i,
    input  logic [VERI_W-1:0]            veri_i,
    output logic                         hazir_o,
    output logic                         pencere_gecerli_o,
    output logic [VERI_W-1:0]            g0_o,
    output logic [VERI_W-1:0]            g1_o,
    output logic [VERI_W-1:0]            g2_o,
    output logic [VERI_W-1:0]            g3_o,
    output logic [VERI_W-1:0]            g4_o,
    output logic [VERI_W-1:0]            g5_o,
    output logic [VERI_W-1:0]            g6_o,
    output logic [VERI_W-1:0]            g7_o,
    output logic [VERI_W-1:0]            g8_o,
    output logic [$clog2(YUKSEKLIK)-1:0] satir_o,
    output logic [$clog2(GENISLIK)-1:0]  sutun_o,
    output logic                         cerceve_bitti_o
);

    localparam int SW = $clog2(GENISLIK);
    localparam int RW = $clog2(YUKSEKLIK);

    durum_t durum, durum_sonraki;
    logic kabul, adim, cikis, son_piksel, son_pencere;
    logic gecerli_q, bitti_q;

    logic [SW-1:0] giris_sutun, giris_sutun_sonraki, cikis_sutun;
    logic [RW-1:0] giris_satir, cikis_satir;

    logic [VERI_W-1:0] lb1_oku, lb2_oku;
    logic [VERI_W-1:0] yeni    [3];
    logic [VERI_W-1:0] orta    [3];
    logic [VERI_W-1:0] sol     [3];
    logic [VERI_W-1:0] pencere [9];
    logic [VERI_W-1:0] g_q     [9];

    assign son_piksel  = (giris_satir == RW'(YUKSEKLIK-1)) && (giris_sutun == SW'(GENISLIK-1));
    assign son_pencere = (cikis_satir == RW'(YUKSEKLIK-1)) && (cikis_sutun == SW'(GENISLIK-1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            durum <= BOS;
        end else if (en_i) begin
            durum <= durum_sonraki;
        end
    end

    always_comb begin
        durum_sonraki = durum;
        case (durum)
            BOS:     if (kabul) durum_sonraki = DOLDUR;
            DOLDUR:  if (kabul && giris_satir == RW'(1) && giris_sutun == '0) durum_sonraki = AKIS;
            AKIS:    if (kabul && son_piksel) durum_sonraki = BOSALT;
            BOSALT:  if (son_pencere) durum_sonraki = BOS;
            default: durum_sonraki = BOS;
        endcase
    end

    // BOSALT steps the pipeline with virtual pixels; the bottom row is padded.
    always_comb begin
        hazir_o = (durum != BOSALT);
        kabul   = en_i & veri_gecerli_i & hazir_o;
        adim    = kabul | (en_i & (durum == BOSALT));
        cikis   = (kabul & (durum == AKIS)) | (en_i & (durum == BOSALT));
    end

    // Line buffers are read one step ahead so data is ready at the accept edge.
    always_comb begin
        if (rst_i) begin
            giris_sutun_sonraki = '0;
        end else if (!adim) begin
            giris_sutun_sonraki = giris_sutun;
        end else if ((durum == BOSALT && son_pencere) || giris_sutun == SW'(GENISLIK-1)) begin
            giris_sutun_sonraki = '0;
        end else begin
            giris_sutun_sonraki = giris_sutun + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            giris_sutun <= '0;
            giris_satir <= '0;
            cikis_sutun <= '0;
            cikis_satir <= '0;
        end else begin
            if (adim) begin
                giris_sutun <= giris_sutun_sonraki;
                if (durum == BOSALT && son_pencere) begin
                    giris_satir <= '0;
                end else if (giris_sutun == SW'(GENISLIK-1)) begin
                    giris_satir <= (giris_satir == RW'(YUKSEKLIK-1)) ? '0 : giris_satir + 1'b1;
                end
            end
            if (cikis) begin
                if (cikis_sutun == SW'(GENISLIK-1)) begin
                    cikis_sutun <= '0;
                    cikis_satir <= (cikis_satir == RW'(YUKSEKLIK-1)) ? '0 : cikis_satir + 1'b1;
                end else begin
                    cikis_sutun <= cikis_sutun + 1'b1;
                end
            end
        end
    end

    satir_tamponu #(.DERINLIK(GENISLIK), .VERI_W(VERI_W), .AW(SW)) u_lb1 (
        .clk_i      (clk_i),
        .yaz_en_i   (adim),
        .yaz_adr_i  (giris_sutun),
        .yaz_veri_i (veri_i),
        .oku_adr_i  (giris_sutun_sonraki),
        .oku_veri_o (lb1_oku)
    );

    satir_tamponu #(.DERINLIK(GENISLIK), .VERI_W(VERI_W), .AW(SW)) u_lb2 (
        .clk_i      (clk_i),
        .yaz_en_i   (adim),
        .yaz_adr_i  (giris_sutun),
        .yaz_veri_i (lb1_oku),
        .oku_adr_i  (giris_sutun_sonraki),
        .oku_veri_o (lb2_oku)
    );

    always_comb begin
        yeni[0] = lb2_oku;
        yeni[1] = lb1_oku;
        yeni[2] = veri_i;
    end

    always_ff @(posedge clk_i) begin
        if (adim) begin
            for (int r = 0; r < 3; r++) begin
                sol[r]  <= orta[r];
                orta[r] <= yeni[r];
            end
        end
    end

    // Padding depends only on the centre coordinates, hiding stale buffer data.
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                pencere[r*3+c] = (c == 0) ? sol[r] : ((c == 1) ? orta[r] : yeni[r]);
                if ((r == 0 && cikis_satir == '0) ||
                    (r == 2 && cikis_satir == RW'(YUKSEKLIK-1)) ||
                    (c == 0 && cikis_sutun == '0) ||
                    (c == 2 && cikis_sutun == SW'(GENISLIK-1))) begin
                    pencere[r*3+c] = PAD_DEGER;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            gecerli_q <= 1'b0;
            bitti_q   <= 1'b0;
            satir_o   <= '0;
            sutun_o   <= '0;
            for (int i = 0; i < 9; i++) begin
                g_q[i] <= '0;
            end
        end else begin
            gecerli_q <= cikis;
            bitti_q   <= cikis & son_pencere;
            if (cikis) begin
                satir_o <= cikis_satir;
                sutun_o <= cikis_sutun;
                for (int i = 0; i < 9; i++) begin
                    g_q[i] <= pencere[i];
                end
            end
        end
    end

    assign pencere_gecerli_o = gecerli_q;
    assign cerceve_bitti_o   = bitti_q;
    assign g0_o = g_q[0];
    assign g1_o = g_q[1];
    assign g2_o = g_q[2];
    assign g3_o = g_q[3];
    assign g4_o = g_q[4];
    assign g5_o = g_q[5];
    assign g6_o = g_q[6];
    assign g7_o = g_q[7];
    assign g8_o = g_q[8];

endmodule

// File: tb/tb_pencere_3x3.sv
// Bench for pencere_3x3: a 4x3 instance for detailed scenarios and a 320x240
// instance for the full-frame run, both checked against a padded-image model.
module tb_pencere_3x3;
    import goruntu_pkg::*;

    typedef logic [8:0][7:0] pen_t;
    localparam int KW = 4, KH = 3, BW = 320, BH = 240;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic k_rst, k_en, k_vg, k_hazir, k_pg, k_bitti;
    piksel_t k_veri;
    piksel_t k_g [9];
    logic [1:0] k_satir, k_sutun;

    logic b_rst, b_en, b_vg, b_hazir, b_pg, b_bitti;
    piksel_t b_veri;
    piksel_t b_g [9];
    logic [7:0] b_satir;
    logic [8:0] b_sutun;

    pencere_3x3 #(.GENISLIK(KW), .YUKSEKLIK(KH), .VERI_W(8), .PAD_DEGER(8'h00)) dut_k (
        .clk_i(clk), .rst_i(k_rst), .en_i(k_en), .veri_gecerli_i(k_vg), .veri_i(k_veri),
        .hazir_o(k_hazir), .pencere_gecerli_o(k_pg),
        .g0_o(k_g[0]), .g1_o(k_g[1]), .g2_o(k_g[2]), .g3_o(k_g[3]), .g4_o(k_g[4]),
        .g5_o(k_g[5]), .g6_o(k_g[6]), .g7_o(k_g[7]), .g8_o(k_g[8]),
        .satir_o(k_satir), .sutun_o(k_sutun), .cerceve_bitti_o(k_bitti)
    );

    pencere_3x3 #(.GENISLIK(BW), .YUKSEKLIK(BH), .VERI_W(8), .PAD_DEGER(8'h00)) dut_b (
        .clk_i(clk), .rst_i(b_rst), .en_i(b_en), .veri_gecerli_i(b_vg), .veri_i(b_veri),
        .hazir_o(b_hazir), .pencere_gecerli_o(b_pg),
        .g0_o(b_g[0]), .g1_o(b_g[1]), .g2_o(b_g[2]), .g3_o(b_g[3]), .g4_o(b_g[4]),
        .g5_o(b_g[5]), .g6_o(b_g[6]), .g7_o(b_g[7]), .g8_o(b_g[8]),
        .satir_o(b_satir), .sutun_o(b_sutun), .cerceve_bitti_o(b_bitti)
    );

    int n_cmp = 0, n_err = 0;
    piksel_t kpix [24];
    pen_t q_pen [$];
    int q_satir [$], q_sutun [$], q_bitti [$], q_kabul [$];
    int bitti_say, hazir_dusuk, stall_pg, stall_deg, ilk_bitti, kabul13;

    function automatic pen_t k_cur();
        pen_t p;
        for (int i = 0; i < 9; i++) p[i] = k_g[i];
        return p;
    endfunction

    // Window n of the small frame held in kpix, zero outside the image.
    function automatic pen_t model_k(input int n);
        pen_t p;
        int r, c, rr, cc;
        r = n / KW;
        c = n % KW;
        for (int dr = 0; dr < 3; dr++) begin
            for (int dc = 0; dc < 3; dc++) begin
                rr = r + dr - 1;
                cc = c + dc - 1;
                if (rr < 0 || rr >= KH || cc < 0 || cc >= KW) p[dr*3+dc] = 8'h00;
                else p[dr*3+dc] = kpix[rr*KW+cc];
            end
        end
        return p;
    endfunction

    // mod 0: valid held, 1: valid toggles, 2: en low 3 cycles mid-flush, 3: random valid/en
    task automatic kare_sur(input int npix, input int nwin, input int mod);
        int sent, cyc, off;
        logic hz, acc, en_v, en_done;
        pen_t prev, cur;
        q_pen.delete(); q_satir.delete(); q_sutun.delete(); q_bitti.delete(); q_kabul.delete();
        sent = 0; cyc = 0; off = 0; en_done = 0;
        bitti_say = 0; hazir_dusuk = 0; stall_pg = 0; stall_deg = 0; ilk_bitti = -1; kabul13 = -1;
        prev = k_cur();
        while (q_pen.size() < nwin && cyc < 400) begin
            hz = k_hazir;
            en_v = 1'b1;
            if (mod == 2 && !hz && !en_done && hazir_dusuk == 2) begin
                off = 3;
                en_done = 1'b1;
            end
            if (off > 0) begin
                en_v = 1'b0;
                off--;
            end
            if (mod == 3 && $urandom_range(0, 7) == 0) en_v = 1'b0;
            k_en = en_v;
            if (mod == 1) k_vg = (sent < npix) && (cyc % 2 == 0);
            else if (mod == 3) k_vg = (sent < npix) && ($urandom_range(0, 1) == 1);
            else k_vg = (sent < npix);
            k_veri = (sent < npix) ? kpix[sent] : 8'($urandom_range(0, 255));
            acc = en_v & k_vg & hz;
            @(posedge clk);
            #1;
            cur = k_cur();
            if (acc) begin
                sent++;
                if (sent == 13) kabul13 = cyc;
            end
            if (!hz && en_v) hazir_dusuk++;
            if (!en_v) begin
                if (k_pg) stall_pg++;
                if (cur !== prev) stall_deg++;
            end
            if (k_bitti) begin
                bitti_say++;
                if (ilk_bitti < 0) ilk_bitti = cyc;
            end
            if (k_pg) begin
                q_pen.push_back(cur);
                q_satir.push_back(int'(k_satir));
                q_sutun.push_back(int'(k_sutun));
                q_bitti.push_back(int'(k_bitti));
                q_kabul.push_back(sent);
            end
            prev = cur;
            cyc++;
        end
        k_vg = 1'b0;
        k_en = 1'b1;
    endtask

    task automatic test_reset();
        k_rst = 1'b1; b_rst = 1'b1; k_en = 1'b1; b_en = 1'b1;
        k_vg = 1'b0; b_vg = 1'b0; k_veri = 8'h00; b_veri = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (k_pg !== 1'b0 || k_bitti !== 1'b0 || k_cur() !== '0 || k_satir !== 2'd0 || k_sutun !== 2'd0) begin
            n_err++;
            $display("FAIL reset_outputs: pg=%b bitti=%b g=%h satir=%0d sutun=%0d, required all zero",
                     k_pg, k_bitti, k_cur(), k_satir, k_sutun);
        end
        n_cmp++;
        if (k_hazir !== 1'b1 || b_hazir !== 1'b1 || b_pg !== 1'b0) begin
            n_err++;
            $display("FAIL reset_hazir: k_hazir=%b b_hazir=%b b_pg=%b, required 1 1 0", k_hazir, b_hazir, b_pg);
        end
        k_rst = 1'b0; b_rst = 1'b0;
    endtask

    task automatic test_temel();
        pen_t ilk, son;
        for (int i = 0; i < 12; i++) kpix[i] = 8'(i + 1);
        kare_sur(12, 12, 0);
        ilk = '0; ilk[4] = 8'd1; ilk[5] = 8'd2; ilk[7] = 8'd5; ilk[8] = 8'd6;
        son = '0; son[0] = 8'd7; son[1] = 8'd8; son[3] = 8'd11; son[4] = 8'd12;
        n_cmp++;
        if (q_pen.size() != 12) begin
            n_err++;
            $display("FAIL temel_count: got %0d windows, required 12", q_pen.size());
        end
        for (int i = 0; i < q_pen.size(); i++) begin
            n_cmp++;
            if (q_pen[i] !== model_k(i) || q_satir[i] != i / KW || q_sutun[i] != i % KW) begin
                n_err++;
                $display("FAIL temel_win%0d: got %h (%0d,%0d), required %h (%0d,%0d)",
                         i, q_pen[i], q_satir[i], q_sutun[i], model_k(i), i / KW, i % KW);
            end
        end
        if (q_pen.size() == 12) begin
            n_cmp++;
            if (q_pen[0] !== ilk || q_kabul[0] != 6) begin
                n_err++;
                $display("FAIL temel_first: got %h after %0d accepts, required %h after 6", q_pen[0], q_kabul[0], ilk);
            end
            n_cmp++;
            if (q_pen[11] !== son || q_bitti[11] != 1) begin
                n_err++;
                $display("FAIL temel_last: got %h bitti=%0d, required %h bitti=1", q_pen[11], q_bitti[11], son);
            end
        end
        n_cmp++;
        if (hazir_dusuk != 5 || bitti_say != 1) begin
            n_err++;
            $display("FAIL temel_flush: hazir low %0d cycles, bitti %0d, required 5 and 1", hazir_dusuk, bitti_say);
        end
        n_cmp++;
        if (k_hazir !== 1'b1) begin
            n_err++;
            $display("FAIL temel_hazir_after: got %b, required 1", k_hazir);
        end
    endtask

    task automatic test_kabarcik();
        int gec_hata;
        for (int i = 0; i < 12; i++) kpix[i] = 8'(i + 1);
        kare_sur(12, 12, 1);
        n_cmp++;
        if (q_pen.size() != 12 || bitti_say != 1) begin
            n_err++;
            $display("FAIL kabarcik_count: got %0d windows %0d bitti, required 12 and 1", q_pen.size(), bitti_say);
        end
        for (int i = 0; i < q_pen.size(); i++) begin
            n_cmp++;
            if (q_pen[i] !== model_k(i) || q_satir[i] != i / KW || q_sutun[i] != i % KW) begin
                n_err++;
                $display("FAIL kabarcik_win%0d: got %h, required %h", i, q_pen[i], model_k(i));
            end
        end
        gec_hata = 0;
        for (int i = 0; i < 7 && i < q_kabul.size(); i++) if (q_kabul[i] != i + 6) gec_hata++;
        n_cmp++;
        if (gec_hata != 0) begin
            n_err++;
            $display("FAIL kabarcik_timing: %0d windows not right after accept n+6, required 0", gec_hata);
        end
    endtask

    task automatic test_en_dondur();
        for (int i = 0; i < 12; i++) kpix[i] = 8'(i + 1);
        kare_sur(12, 12, 2);
        n_cmp++;
        if (q_pen.size() != 12 || bitti_say != 1) begin
            n_err++;
            $display("FAIL en_count: got %0d windows %0d bitti, required 12 and 1", q_pen.size(), bitti_say);
        end
        for (int i = 0; i < q_pen.size(); i++) begin
            n_cmp++;
            if (q_pen[i] !== model_k(i)) begin
                n_err++;
                $display("FAIL en_win%0d: got %h, required %h", i, q_pen[i], model_k(i));
            end
        end
        n_cmp++;
        if (stall_pg != 0 || stall_deg != 0) begin
            n_err++;
            $display("FAIL en_freeze: %0d windows and %0d output changes while en low, required 0 and 0",
                     stall_pg, stall_deg);
        end
    endtask

    task automatic test_reset_ortasi();
        for (int i = 0; i < 7; i++) begin
            k_en = 1'b1; k_vg = 1'b1; k_veri = 8'(i + 1);
            @(posedge clk);
            #1;
        end
        k_vg = 1'b0;
        k_rst = 1'b1;
        @(posedge clk);
        #1;
        k_rst = 1'b0;
        n_cmp++;
        if (k_pg !== 1'b0 || k_bitti !== 1'b0 || k_cur() !== '0 || k_satir !== 2'd0 ||
            k_sutun !== 2'd0 || k_hazir !== 1'b1) begin
            n_err++;
            $display("FAIL midreset_outputs: pg=%b bitti=%b g=%h hazir=%b, required 0 0 0 1",
                     k_pg, k_bitti, k_cur(), k_hazir);
        end
        for (int i = 0; i < 12; i++) kpix[i] = 8'(100 + i);
        kare_sur(12, 12, 0);
        n_cmp++;
        if (q_pen.size() != 12 || bitti_say != 1) begin
            n_err++;
            $display("FAIL midreset_count: got %0d windows %0d bitti, required 12 and 1", q_pen.size(), bitti_say);
        end
        for (int i = 0; i < q_pen.size(); i++) begin
            n_cmp++;
            if (q_pen[i] !== model_k(i)) begin
                n_err++;
                $display("FAIL midreset_win%0d: got %h, required %h", i, q_pen[i], model_k(i));
            end
        end
    endtask

    task automatic test_rastgele();
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 12; i++) kpix[i] = 8'($urandom_range(1, 255));
            kare_sur(12, 12, 3);
            n_cmp++;
            if (q_pen.size() != 12 || bitti_say != 1) begin
                n_err++;
                $display("FAIL random%0d_count: got %0d windows %0d bitti, required 12 and 1", f, q_pen.size(), bitti_say);
            end
            for (int i = 0; i < q_pen.size(); i++) begin
                n_cmp++;
                if (q_pen[i] !== model_k(i) || q_satir[i] != i / KW || q_sutun[i] != i % KW) begin
                    n_err++;
                    $display("FAIL random%0d_win%0d: got %h, required %h", f, i, q_pen[i], model_k(i));
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 12; i++) begin
            kpix[i] = 8'($urandom_range(1, 255));
            kpix[i+12] = kpix[i];
        end
        kare_sur(24, 24, 0);
        n_cmp++;
        if (q_pen.size() != 24 || bitti_say != 2) begin
            n_err++;
            $display("FAIL b2b_count: got %0d windows %0d bitti, required 24 and 2", q_pen.size(), bitti_say);
        end
        for (int i = 0; i < q_pen.size(); i++) begin
            n_cmp++;
            if (q_pen[i] !== model_k(i % 12) || q_bitti[i] != ((i % 12 == 11) ? 1 : 0)) begin
                n_err++;
                $display("FAIL b2b_win%0d: got %h bitti=%0d, required %h", i, q_pen[i], q_bitti[i], model_k(i % 12));
            end
        end
        n_cmp++;
        if (kabul13 != ilk_bitti + 1) begin
            n_err++;
            $display("FAIL b2b_restart: next frame pixel 0 accepted at cycle %0d, required %0d", kabul13, ilk_bitti + 1);
        end
    endtask

    task automatic test_tam_kare();
        int sent, wins, cyc, hatali, bitti, n4, n6, n9, ff, r, c, rr, cc;
        logic hz, acc;
        piksel_t beklenen;
        sent = 0; wins = 0; cyc = 0; hatali = 0; bitti = 0; n4 = 0; n6 = 0; n9 = 0;
        b_en = 1'b1;
        b_veri = 8'hFF;
        while (wins < BW * BH && cyc < 78000) begin
            hz = b_hazir;
            b_vg = (sent < BW * BH);
            acc = b_vg & hz;
            @(posedge clk);
            #1;
            if (acc) sent++;
            if (b_bitti) bitti++;
            if (b_pg) begin
                r = wins / BW;
                c = wins % BW;
                ff = 0;
                for (int i = 0; i < 9; i++) begin
                    rr = r + i / 3 - 1;
                    cc = c + i % 3 - 1;
                    beklenen = (rr >= 0 && rr < BH && cc >= 0 && cc < BW) ? 8'hFF : 8'h00;
                    if (b_g[i] !== beklenen) hatali++;
                    if (b_g[i] === 8'hFF) ff++;
                end
                if (int'(b_satir) != r || int'(b_sutun) != c) hatali++;
                if (ff == 4) n4++;
                else if (ff == 6) n6++;
                else if (ff == 9) n9++;
                wins++;
            end
            cyc++;
        end
        b_vg = 1'b0;
        n_cmp++;
        if (wins != BW * BH) begin
            n_err++;
            $display("FAIL full_count: got %0d windows, required %0d", wins, BW * BH);
        end
        n_cmp++;
        if (hatali != 0) begin
            n_err++;
            $display("FAIL full_values: %0d wrong window elements or coordinates, required 0", hatali);
        end
        n_cmp++;
        if (n4 != 4 || n6 != 2 * (BW - 2) + 2 * (BH - 2) || n9 != (BW - 2) * (BH - 2)) begin
            n_err++;
            $display("FAIL full_classes: corner/edge/interior %0d/%0d/%0d, required 4/%0d/%0d",
                     n4, n6, n9, 2 * (BW - 2) + 2 * (BH - 2), (BW - 2) * (BH - 2));
        end
        n_cmp++;
        if (bitti != 1) begin
            n_err++;
            $display("FAIL full_bitti: got %0d pulses, required 1", bitti);
        end
    endtask

    initial begin
        test_reset();
        test_temel();
        test_kabarcik();
        test_en_dondur();
        test_reset_ortasi();
        test_rastgele();
        test_back_to_back();
        test_tam_kare();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pencere_3x3.md
# pencere_3x3

Streaming 3×3 neighbourhood window generator for the grayscale/binary image pipeline. It accepts one raster-order pixel per handshake and emits the zero-padded 3×3 window centred on each pixel, in raster order. It feeds the erosion/morphology stage directly, so that stage no longer needs a full zero-bordered frame copy in memory. It stores only two image lines.

## Interface
- GENISLIK, 320, pixels per line (≥3)
- YUKSEKLIK, 240, lines per frame (≥2)
- VERI_W, 8, pixel width in bits
- PAD_DEGER, 0, value substituted for out-of-image neighbours
- Clocking: one clock, `clk_i`; reset is synchronous and active-high, `rst_i`.
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- en_i  in  1  global enable; low freezes all state and outputs
- veri_gecerli_i  in  1  input pixel valid
- veri_i  in  VERI_W  input pixel
- hazir_o  out  1  ready; pixel accepted when veri_gecerli_i & hazir_o & en_i
- pencere_gecerli_o  out  1  window valid, one-cycle pulse per window
- g0_o … g8_o  out  VERI_W each  window, row-major: g0=(r-1,c-1), g4=(r,c) centre, g8=(r+1,c+1)
- satir_o  out  $clog2(YUKSEKLIK)  centre row of current window
- sutun_o  out  $clog2(GENISLIK)  centre column of current window
- cerceve_bitti_o  out  1  pulses together with the last window of a frame

## Operation
- Storage:
  - Two line buffers of GENISLIK×VERI_W hold lines r-1 and r.
  - A 3×3 register array shifts one column per step.
- Input counters track the accepted pixel index k (row, column). Output counters track the centre index k-(GENISLIK+1).
- Padding:
  - Any window position outside 0…YUKSEKLIK-1 / 0…GENISLIK-1 outputs PAD_DEGER.
  - Padding is decided from the centre coordinates only. Stale line-buffer contents never reach the outputs.
- State machine:
  - BOS: idle, hazir_o=1. First accepted pixel moves to DOLDUR.
  - DOLDUR: accepts pixels 0…GENISLIK, emits no windows. On accepting pixel GENISLIK, moves to AKIS.
  - AKIS: each accepted pixel k emits window k-(GENISLIK+1). Accepting pixel GENISLIK·YUKSEKLIK-1 moves to BOSALT.
  - BOSALT: hazir_o=0. Emits the remaining GENISLIK+1 windows, one per enabled cycle, with bottom/right padding. The last one asserts cerceve_bitti_o, then the machine returns to BOS.
- Exactly GENISLIK·YUKSEKLIK windows are emitted per frame.
- Arithmetic: coordinate counters wrap at GENISLIK/YUKSEKLIK. No pixel arithmetic; data passes unmodified.

## Timing
- Reset values: pencere_gecerli_o=0, cerceve_bitti_o=0, g0_o…g8_o=0, satir_o=0, sutun_o=0, state BOS. After reset hazir_o=1.
- Latency: the window triggered by an accepted pixel is registered and valid the next cycle.
- veri_gecerli_i low in DOLDUR/AKIS is a bubble: no window, counters hold.
- en_i low: no acceptance, no window, outputs hold their last values (pencere_gecerli_o forced 0), the BOSALT count pauses.
- Input during BOSALT is ignored (hazir_o=0). The upstream stage must hold its pixel.
- rst_i mid-frame: the next cycle is in BOS with all outputs at reset values. The partial frame is discarded and never completed.
- Back-to-back frames: the cycle after cerceve_bitti_o, hazir_o=1 and pixel 0 of the next frame may be accepted.

## Structure
- Package goruntu_pkg holds:
  - GENISLIK, YUKSEKLIK, VERI_W defaults
  - the piksel_t typedef
  - the state enum {BOS, DOLDUR, AKIS, BOSALT}
- Sub-module satir_tamponu: GENISLIK×VERI_W simple dual-port RAM, read-before-write, registered read. Two instances.

## Test plan
- Small frame, GENISLIK=4, YUKSEKLIK=3, p(r,c)=4r+c+1, veri_gecerli_i held high:
  - first window appears the cycle after the 6th accept: g0..g8 = 0,0,0,0,1,2,0,5,6
  - hazir_o stays low for 5 cycles
  - 12 windows in total; the last is 7,8,0,11,12,0,0,0,0 with cerceve_bitti_o=1
- Same frame with veri_gecerli_i toggling 1/0 every cycle: identical 12 windows and values, gaps only at bubbles.
- en_i low for 3 cycles in the middle of BOSALT: outputs freeze, no window during those cycles, still exactly 12 windows, correct final values.
- rst_i after 7 pixels, then a full new frame of p(r,c)=100+4r+c:
  - all outputs 0 the cycle after reset
  - first window is 0,0,0,0,100,101,0,104,105, with no stale data
- Full 320×240 frame of all 255:
  - 76800 windows
  - corner windows have four 255s, edge windows six, interior windows nine
  - cerceve_bitti_o asserts once
- Two frames back-to-back with veri_gecerli_i held high: no accept while hazir_o=0, and the second frame's windows are bit-exact with the first.
